snoop_bus_arbiter: RTL and testbench
====================================

// Module: snoop_bus_arbiter
// PURPOSE
//  Arbitrates the shared snooping bus between NUM_CPU cache controllers and sequences each
//  coherence transaction: broadcast, snoop-response collection, owner write-back and memory access.
//  Sits between the per-CPU MSI cache controllers and the memory port.
//  Guarantees one transaction in flight and a deterministic order of coherence events.
// PARAMETERS
//  NUM_CPU   4   number of requesting caches (>=2)
//  ADDR_W    16  block address width
//  SRC_W     2   width of bus_src; must be >= clog2(NUM_CPU)
// PORTS
//  clock      in   1              single system clock, rising edge
//  reset_n    in   1              asynchronous, active-low reset
//  req        in   NUM_CPU        per-CPU request, level, held until done
//  req_op     in   2*NUM_CPU      per-CPU op: 00 read_miss, 01 write_miss, 10 invalidate, 11 illegal
//  req_addr   in   ADDR_W*NUM_CPU per-CPU block address
//  grant      out  NUM_CPU        one-hot owner, held from BCAST through DONE
//  done       out  NUM_CPU        one-cycle completion pulse to owner
//  bus_valid  out  1              broadcast strobe, exactly one cycle per transaction
//  bus_op     out  2              broadcast op, held while grant!=0
//  bus_addr   out  ADDR_W         broadcast address, held while grant!=0
//  bus_src    out  SRC_W          owner index, held while grant!=0
//  snoop_ack  in   NUM_CPU        per-CPU snoop-complete, may be a pulse
//  snoop_wb   in   NUM_CPU        per-CPU "I was exclusive, writing back"; sampled with snoop_ack
//  wb_done    in   1              write-back of dirty block finished
//  mem_req    out  1              memory request, level, until mem_ack
//  mem_ack    in   1              memory access finished
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; ack/wb collectors cleared; round-robin pointer 0.
//  FSM: IDLE -> BCAST -> SNOOP -> [WB] -> [MEM] -> DONE -> IDLE.
//  IDLE: if any req, pick winner, latch op/addr/src, go BCAST. Otherwise stay.
//  BCAST: grant=onehot(winner), bus_valid=1 for this cycle only, go SNOOP.
//  SNOOP: OR snoop_ack/snoop_wb into sticky collectors. Owner bit masked (treated acked, wb ignored).
//   Leave SNOOP when all non-owner acks are collected, including acks arriving this cycle.
//   Any wb -> WB. Else invalidate -> DONE. Else read/write miss -> MEM.
//  WB: wait wb_done. Read/write miss -> DONE (memory access aborted, mem_req never raised).
//  MEM: mem_req=1 until mem_ack, then DONE.
//  DONE: done[owner]=1 for one cycle, grant still held; next IDLE clears grant/bus_* and collectors.
//  Latency: req sampled at T0 -> grant/bus_valid at T1, SNOOP at T2.
//   All acks at T2 on an invalidate -> done at T3, grant=0 at T4. Next grant no earlier than T5.
//  Illegal op 11: IDLE -> DONE directly; no bus_valid, no mem_req; done pulse to owner.
//  Owner dropping req mid-transaction: ignored, transaction completes, done still pulsed.
//  Multiple snoop_wb set: protocol error; handled as a single WB (one wb_done awaited).
//  wb_done/mem_ack outside WB/MEM: ignored. snoop_ack outside SNOOP: ignored.
//  reset_n low mid-transaction: immediate return to IDLE, all outputs 0, no done pulse.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: winner is the first requester at index > last owner, wrapping.
//   Pointer updates on each grant.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer register.
// STRUCTURE
//  Package snoop_pkg: op encodings (READ_MISS=2'b00, WRITE_MISS=2'b01, INVALIDATE=2'b10)
//   and the FSM state enum (IDLE, BCAST, SNOOP, WB, MEM, DONE). Shared with cache controllers.
//  Sub-module snoop_arb_pick: combinational winner select (req, last_owner -> onehot, index).
//   Contains the ARB_ROUND_ROBIN_EN variant.
//  Top: FSM, latch registers, ack/wb collectors.
// TESTING
//  CPU1 invalidate, addr 0x0040, acks CPU0/2/3 at T2 -> bus_valid T1 only, done[1] at T3, no mem_req.
//  CPU0 read_miss, CPU2 asserts snoop_wb+ack, wb_done 2 cycles later -> DONE, mem_req stays 0 throughout.
//  CPU3 write_miss, acks, no wb, mem_ack after 4 cycles -> mem_req high 4 cycles, then done[3] pulse.
//  req=4'b1011 repeatedly -> fixed: CPU0 always wins; RR_EN: grant order CPU0, CPU1, CPU3, CPU0.
//  Acks from CPU2 at T2, CPU0/3 at T5 -> stays SNOOP until T5, sticky collection verified.
//  reset_n low during MEM -> grant, mem_req, bus_* = 0 asynchronously; no done; IDLE after release.

Source files
------------

// File: rtl/snoop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : snoop_pkg                                                      |
// | Purpose   : Shared encodings for the snooping bus: coherence op codes and  |
// |             the arbiter FSM state values. Also used by cache controllers.  |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package snoop_pkg;

  // Coherence operation encodings carried on req_op / bus_op
  localparam logic [1:0] OP_READ_MISS  = 2'b00;
  localparam logic [1:0] OP_WRITE_MISS = 2'b01;
  localparam logic [1:0] OP_INVALIDATE = 2'b10;
  localparam logic [1:0] OP_ILLEGAL    = 2'b11;

  // Arbiter FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BCAST = 3'd1;
  localparam logic [2:0] ST_SNOOP = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_MEM   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/snoop_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : snoop_arb_pick                                                 |
// | Purpose   : Combinational winner select for the snoop bus arbiter.         |
// |             Macro ARB_ROUND_ROBIN_EN: winner is the first requester at an  |
// |             index above last_owner_i, wrapping. Otherwise fixed priority,  |
// |             lowest index wins and last_owner_i does not exist.             |
// | Ports     : req_i        request vector                                    |
// |             last_owner_i previous owner index (round-robin build only)     |
// |             onehot_o     one-hot winner, zero when no request              |
// |             index_o      winner index                                      |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module snoop_arb_pick #(
  parameter int NUM_CPU = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_CPU-1:0] req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [SRC_W-1:0]   last_owner_i,
`endif
  output logic [NUM_CPU-1:0] onehot_o,
  output logic [SRC_W-1:0]   index_o
);

`ifdef ARB_ROUND_ROBIN_EN
  int c;

  // Scan offsets from farthest to nearest; the last hit (smallest offset
  // after last_owner_i) overwrites earlier ones and wins.
  always_comb begin
    onehot_o = '0;
    index_o  = '0;
    c        = 0;
    for (int k = NUM_CPU; k >= 1; k--) begin
      c = (int'(last_owner_i) + k) % NUM_CPU;
      if (req_i[c]) begin
        onehot_o    = '0;
        onehot_o[c] = 1'b1;
        index_o     = SRC_W'(c);
      end
    end
  end
`else
  // Highest index scanned first so the lowest requester is the final write.
  always_comb begin
    onehot_o = '0;
    index_o  = '0;
    for (int k = NUM_CPU - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        onehot_o    = '0;
        onehot_o[k] = 1'b1;
        index_o     = SRC_W'(k);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : snoop_bus_arbiter                                              |
// | Purpose   : Arbitrates the shared snooping bus between NUM_CPU caches and  |
// |             sequences one coherence transaction at a time:                 |
// |             IDLE -> BCAST -> SNOOP -> [WB] -> [MEM] -> DONE -> IDLE.       |
// |             Macro ARB_ROUND_ROBIN_EN selects round-robin arbitration,      |
// |             otherwise fixed priority (lowest index wins).                  |
// | Ports     : clock, reset_n          clock / async active-low reset         |
// |             req, req_op, req_addr   per-CPU request, op, block address     |
// |             grant, done             one-hot owner / completion pulse       |
// |             bus_valid/op/addr/src   broadcast strobe and payload           |
// |             snoop_ack, snoop_wb     per-CPU snoop response                 |
// |             wb_done                 owner write-back finished              |
// |             mem_req, mem_ack        memory port handshake                  |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 16,
  parameter int SRC_W   = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_CPU-1:0]        req,
  input  logic [2*NUM_CPU-1:0]      req_op,
  input  logic [ADDR_W*NUM_CPU-1:0] req_addr,
  output logic [NUM_CPU-1:0]        grant,
  output logic [NUM_CPU-1:0]        done,
  output logic                      bus_valid,
  output logic [1:0]                bus_op,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [SRC_W-1:0]          bus_src,
  input  logic [NUM_CPU-1:0]        snoop_ack,
  input  logic [NUM_CPU-1:0]        snoop_wb,
  input  logic                      wb_done,
  output logic                      mem_req,
  input  logic                      mem_ack
);

  logic [2:0]         state_q, state_d;
  logic [1:0]         op_q,    op_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [SRC_W-1:0]   src_q,   src_d;
  logic [NUM_CPU-1:0] ack_q,   ack_d;
  logic [NUM_CPU-1:0] wb_q,    wb_d;

  logic [NUM_CPU-1:0] win_oh;
  logic [SRC_W-1:0]   win_idx;
  logic [NUM_CPU-1:0] owner_oh;
  logic [NUM_CPU-1:0] ack_all;
  logic [NUM_CPU-1:0] wb_all;
  logic               active;

`ifdef ARB_ROUND_ROBIN_EN
  logic [SRC_W-1:0]   last_q, last_d;

  snoop_arb_pick #(.NUM_CPU(NUM_CPU), .SRC_W(SRC_W)) u_pick (
    .req_i        (req),
    .last_owner_i (last_q),
    .onehot_o     (win_oh),
    .index_o      (win_idx)
  );
`else
  snoop_arb_pick #(.NUM_CPU(NUM_CPU), .SRC_W(SRC_W)) u_pick (
    .req_i    (req),
    .onehot_o (win_oh),
    .index_o  (win_idx)
  );
`endif

  assign owner_oh = NUM_CPU'(1) << src_q;
  assign active   = (state_q != ST_IDLE);

  // Include this cycle's acks so SNOOP can exit without an extra cycle.
  // The owner never snoops itself: it counts as acked and its wb is ignored.
  // A write-back flag only counts when accompanied by its ack.
  assign ack_all = ack_q | snoop_ack | owner_oh;
  assign wb_all  = (wb_q | (snoop_wb & snoop_ack)) & ~owner_oh;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    src_d   = src_q;
    ack_d   = ack_q;
    wb_d    = wb_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ack_d = '0;
        wb_d  = '0;
        if (|win_oh) begin
          op_d   = req_op[int'(win_idx)*2 +: 2];
          addr_d = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          src_d  = win_idx;
`ifdef ARB_ROUND_ROBIN_EN
          last_d = win_idx;
`endif
          // Illegal ops never touch the bus; the owner just gets its done.
          state_d = (req_op[int'(win_idx)*2 +: 2] == OP_ILLEGAL) ? ST_DONE : ST_BCAST;
        end
      end
      ST_BCAST: state_d = ST_SNOOP;
      ST_SNOOP: begin
        ack_d = ack_q | snoop_ack;
        wb_d  = wb_q | (snoop_wb & snoop_ack);
        if (&ack_all) begin
          if (|wb_all)                    state_d = ST_WB;
          else if (op_q == OP_INVALIDATE) state_d = ST_DONE;
          else                            state_d = ST_MEM;
        end
      end
      // The write-back supplies the data, so memory access is skipped.
      ST_WB:   if (wb_done) state_d = ST_DONE;
      ST_MEM:  if (mem_ack) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      ack_q   <= '0;
      wb_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      ack_q   <= ack_d;
      wb_q    <= wb_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign grant     = active ? owner_oh : '0;
  assign done      = (state_q == ST_DONE) ? owner_oh : '0;
  assign bus_valid = (state_q == ST_BCAST);
  assign bus_op    = active ? op_q   : '0;
  assign bus_addr  = active ? addr_q : '0;
  assign bus_src   = active ? src_q  : '0;
  assign mem_req   = (state_q == ST_MEM);

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_snoop_bus_arbiter                                           |
// | Purpose   : Directed self-checking bench for snoop_bus_arbiter (4 CPUs).   |
// |             Expected arbitration order follows ARB_ROUND_ROBIN_EN.         |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_snoop_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [63:0] req_addr;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        bus_valid;
  logic [1:0]  bus_op;
  logic [15:0] bus_addr;
  logic [1:0]  bus_src;
  logic [3:0]  snoop_ack;
  logic [3:0]  snoop_wb;
  logic        wb_done;
  logic        mem_req;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;
  int mem_cnt = 0;
  int bv_cnt  = 0;
  int m0, b0;
  logic [3:0] arb_exp [4];

  always #5 clock = ~clock;

  snoop_bus_arbiter #(.NUM_CPU(4), .ADDR_W(16), .SRC_W(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .grant     (grant),
    .done      (done),
    .bus_valid (bus_valid),
    .bus_op    (bus_op),
    .bus_addr  (bus_addr),
    .bus_src   (bus_src),
    .snoop_ack (snoop_ack),
    .snoop_wb  (snoop_wb),
    .wb_done   (wb_done),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack)
  );

  // Cycle counters of mem_req / bus_valid, sampled at each rising edge.
  always @(posedge clock) begin
    if (mem_req === 1'b1)   mem_cnt <= mem_cnt + 1;
    if (bus_valid === 1'b1) bv_cnt  <= bv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    arb_exp[0] = 4'b0001; arb_exp[1] = 4'b0010; arb_exp[2] = 4'b1000; arb_exp[3] = 4'b0001;
`else
    arb_exp[0] = 4'b0001; arb_exp[1] = 4'b0001; arb_exp[2] = 4'b0001; arb_exp[3] = 4'b0001;
`endif
    reset_n = 1'b0; req = '0; req_op = '0; req_addr = '0;
    snoop_ack = '0; snoop_wb = '0; wb_done = 1'b0; mem_ack = 1'b0;

    // ---- reset state
    tick; tick;
    chk("rst_grant", grant, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_bus_addr", bus_addr, 0);
    reset_n = 1'b1;
    tick;

    // ---- CPU1 invalidate 0x0040, acks from 0/2/3 in the first SNOOP cycle
    m0 = mem_cnt;
    req = 4'b0010; req_op = 8'b00_00_10_00; req_addr = {16'h0, 16'h0, 16'h0040, 16'h0};
    tick; // T1
    chk("inv_grant_t1", grant, 4'b0010);
    chk("inv_bv_t1", bus_valid, 1);
    chk("inv_addr_t1", bus_addr, 16'h0040);
    chk("inv_op_t1", bus_op, 2'b10);
    chk("inv_src_t1", bus_src, 1);
    tick; // T2
    chk("inv_bv_t2", bus_valid, 0);
    chk("inv_grant_t2", grant, 4'b0010);
    snoop_ack = 4'b1101;
    tick; // T3
    chk("inv_done_t3", done, 4'b0010);
    chk("inv_grant_t3", grant, 4'b0010);
    snoop_ack = '0; req = '0;
    tick; // T4
    chk("inv_grant_t4", grant, 0);
    chk("inv_done_t4", done, 0);
    chk("inv_busaddr_t4", bus_addr, 0);
    chk("inv_no_mem", mem_cnt - m0, 0);

    // ---- CPU0 read miss, CPU2 writes back, wb_done two cycles later
    m0 = mem_cnt;
    req = 4'b0001; req_op = 8'h00; req_addr = {48'h0, 16'h1234};
    tick; // T1
    chk("wb_grant_t1", grant, 4'b0001);
    chk("wb_addr_t1", bus_addr, 16'h1234);
    tick; // T2
    snoop_ack = 4'b1110; snoop_wb = 4'b0100;
    tick; // T3 (WB)
    snoop_ack = '0; snoop_wb = '0;
    chk("wb_done_t3", done, 0);
    chk("wb_memreq_t3", mem_req, 0);
    tick; // T4
    chk("wb_done_t4", done, 0);
    wb_done = 1'b1;
    tick; // T5
    chk("wb_done_t5", done, 4'b0001);
    wb_done = 1'b0; req = '0;
    tick; // T6
    chk("wb_grant_t6", grant, 0);
    chk("wb_no_mem", mem_cnt - m0, 0);

    // ---- sticky collection: CPU1 invalidate, ack CPU2 at T2, CPU0/3 at T5
    req = 4'b0010; req_op = 8'b00_00_10_00; req_addr = {16'h0, 16'h0, 16'h0040, 16'h0};
    tick; // T1
    tick; // T2
    snoop_ack = 4'b0100;
    tick; // T3
    snoop_ack = '0;
    chk("sticky_done_t3", done, 0);
    chk("sticky_grant_t3", grant, 4'b0010);
    tick; // T4
    chk("sticky_done_t4", done, 0);
    tick; // T5
    chk("sticky_done_t5", done, 0);
    snoop_ack = 4'b1001;
    tick; // T6
    chk("sticky_done_t6", done, 4'b0010);
    snoop_ack = '0; req = '0;
    tick; // T7
    chk("sticky_grant_t7", grant, 0);

    // ---- CPU3 write miss, mem_ack after 4 cycles of mem_req
    m0 = mem_cnt;
    req = 4'b1000; req_op = 8'b01_00_00_00; req_addr = {16'hBEEF, 48'h0};
    tick; // T1
    chk("wm_op_t1", bus_op, 2'b01);
    chk("wm_src_t1", bus_src, 3);
    chk("wm_addr_t1", bus_addr, 16'hBEEF);
    tick; // T2
    snoop_ack = 4'b0111;
    tick; // T3 (MEM)
    snoop_ack = '0;
    for (int i = 0; i < 4; i++) begin
      chk("wm_memreq_hi", mem_req, 1);
      chk("wm_done_lo", done, 0);
      if (i == 3) mem_ack = 1'b1;
      tick;
    end
    chk("wm_done_t7", done, 4'b1000);
    chk("wm_memreq_t7", mem_req, 0);
    chk("wm_mem_cycles", mem_cnt - m0, 4);
    mem_ack = 1'b0; req = '0;
    tick;
    chk("wm_grant_t8", grant, 0);

    // ---- arbitration with req=1011 held (previous owner CPU3)
    req = 4'b1011; req_op = 8'b10_10_10_10; req_addr = '0;
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 8 && bus_valid !== 1'b1; n++) tick;
      chk("arb_bv", bus_valid, 1);
      chk("arb_grant", grant, arb_exp[t]);
      tick; // SNOOP
      snoop_ack = ~grant;
      tick; // DONE
      chk("arb_done", done, arb_exp[t]);
      snoop_ack = '0;
      tick; // IDLE
    end
    req = '0;
    tick; tick;

    // ---- illegal op from CPU2: straight to DONE, no bus traffic
    m0 = mem_cnt; b0 = bv_cnt;
    req = 4'b0100; req_op = 8'b00_11_00_00;
    tick; // T1
    chk("ill_done_t1", done, 4'b0100);
    chk("ill_bv_t1", bus_valid, 0);
    req = '0;
    tick;
    chk("ill_done_t2", done, 0);
    chk("ill_grant_t2", grant, 0);
    chk("ill_no_bv", bv_cnt - b0, 0);
    chk("ill_no_mem", mem_cnt - m0, 0);

    // ---- reset asserted in MEM
    req = 4'b0100; req_op = 8'h00; req_addr = {16'h0, 16'h00AA, 32'h0};
    tick; // T1
    tick; // T2
    snoop_ack = 4'b1011;
    tick; // T3 (MEM)
    snoop_ack = '0;
    chk("rstmem_memreq_pre", mem_req, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("rstmem_grant", grant, 0);
    chk("rstmem_memreq", mem_req, 0);
    chk("rstmem_bv", bus_valid, 0);
    chk("rstmem_addr", bus_addr, 0);
    chk("rstmem_src", bus_src, 0);
    req = '0;
    tick;
    chk("rstmem_done", done, 0);
    reset_n = 1'b1;
    tick;
    chk("rstmem_idle_grant", grant, 0);
    chk("rstmem_idle_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
